// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grant, bus parking, turnaround insertion,
// hidden arbitration during busy bus and revocation of unused grants.
module pci_arbiter #(
    parameter int N       = 4,
    parameter int PARK    = 0,
    parameter int TIMEOUT = 16
) (
    input  logic         PCI_CLK,
    input  logic         RESET_n,
    input  logic [N-1:0] REQ_n,
    input  logic         FRAME_n,
    input  logic         IRDY_n,
    output logic [N-1:0] GNT_n,
    output logic [2:0]   GNT_IDX,
    output logic         GNT_VLD,
    output logic         TMO
);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_PARK  = 3'd1,
        ST_TURN  = 3'd2,
        ST_GRANT = 3'd3,
        ST_BUSY  = 3'd4
    } state_t;

    localparam logic [2:0] PARK_IDX = 3'(PARK);
    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

    state_t       state_r;
    state_t       nxt_state_s;
    logic [2:0]   owner_r;
    logic [2:0]   last_r;
    logic [2:0]   nxt_owner_s;
    logic [2:0]   win_idx_s;
    logic         win_vld_s;
    logic         nxt_tmo_s;
    logic         cnt_inc_s;
    logic [4:0]   cnt_r;
    logic         prev_idle_r;
    logic         idle_s;
    logic         start_s;
    logic [7:0]   req_s;
    logic [N-1:0] gnt_n_r;
    logic [2:0]   gnt_idx_r;
    logic         gnt_vld_r;
    logic         tmo_r;

    function automatic logic [N-1:0] gnt_vec(input logic [2:0] idx);
        logic [7:0] v;
        v      = 8'hFF;
        v[idx] = 1'b0;
        return v[N-1:0];
    endfunction

    assign idle_s  = FRAME_n & IRDY_n;
    assign start_s = ~FRAME_n & prev_idle_r;

    // Active-high request vector, padded so any 3-bit index is legal
    always_comb begin
        req_s        = 8'h00;
        req_s[N-1:0] = ~REQ_n;
    end

    // Round-robin winner: scan from last+1, last itself comes at the end of the sweep
    always_comb begin
        logic [3:0] cand;
        logic       hit;
        win_vld_s = 1'b0;
        win_idx_s = 3'd0;
        cand      = 4'd0;
        hit       = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand      = {1'b0, last_r} + 4'(k);
            cand      = (cand >= 4'(N)) ? cand - 4'(N) : cand;
            hit       = !win_vld_s && req_s[cand[2:0]];
            win_idx_s = hit ? cand[2:0] : win_idx_s;
            win_vld_s = win_vld_s | hit;
        end
    end

    // Next-state decision; start outranks timeout and request release
    always_comb begin
        nxt_state_s = state_r;
        nxt_owner_s = owner_r;
        nxt_tmo_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            ST_RST: begin
                nxt_state_s = ST_PARK;
            end
            ST_PARK: begin
                if (win_vld_s && (win_idx_s == PARK_IDX)) begin
                    nxt_state_s = ST_GRANT;
                    nxt_owner_s = PARK_IDX;
                end else if (win_vld_s) begin
                    nxt_state_s = ST_TURN;
                end else begin
                    nxt_state_s = ST_PARK;
                end
            end
            ST_TURN: begin
                if (win_vld_s) begin
                    nxt_state_s = ST_GRANT;
                    nxt_owner_s = win_idx_s;
                end else begin
                    nxt_state_s = ST_PARK;
                end
            end
            ST_GRANT: begin
                if (start_s) begin
                    nxt_state_s = ST_BUSY;
                end else if (idle_s && (cnt_r == TMO_LAST)) begin
                    nxt_state_s = ST_TURN;
                    nxt_tmo_s   = 1'b1;
                end else if (idle_s && !req_s[owner_r]) begin
                    nxt_state_s = ST_TURN;
                end else if (idle_s) begin
                    cnt_inc_s   = 1'b1;
                end else begin
                    nxt_state_s = ST_GRANT;
                end
            end
            ST_BUSY: begin
                // Bus busy: a competing request takes GNT over with no turnaround
                if (!idle_s && win_vld_s && (win_idx_s != owner_r)) begin
                    nxt_state_s = ST_GRANT;
                    nxt_owner_s = win_idx_s;
                end else if (!idle_s) begin
                    nxt_state_s = ST_BUSY;
                end else if (win_vld_s && (win_idx_s != owner_r)) begin
                    nxt_state_s = ST_TURN;
                end else if (win_vld_s) begin
                    nxt_state_s = ST_GRANT;
                end else if (owner_r == PARK_IDX) begin
                    nxt_state_s = ST_PARK;
                end else begin
                    nxt_state_s = ST_TURN;
                end
            end
            default: begin
                nxt_state_s = ST_RST;
            end
        endcase
    end

    // State, arbitration history and registered bus outputs
    always_ff @(posedge PCI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r     <= ST_RST;
            owner_r     <= 3'd0;
            last_r      <= 3'(N - 1);
            cnt_r       <= 5'd0;
            prev_idle_r <= 1'b1;
            gnt_n_r     <= {N{1'b1}};
            gnt_idx_r   <= 3'd0;
            gnt_vld_r   <= 1'b0;
            tmo_r       <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            owner_r     <= nxt_owner_s;
            prev_idle_r <= idle_s;
            tmo_r       <= nxt_tmo_s;
            if ((nxt_state_s == ST_GRANT) && (state_r == ST_GRANT)) begin
                cnt_r <= cnt_r + {4'd0, cnt_inc_s};
            end else begin
                cnt_r <= 5'd0;
            end
            if ((nxt_state_s == ST_GRANT) && (state_r != ST_GRANT)) begin
                last_r <= nxt_owner_s;
            end else begin
                last_r <= last_r;
            end
            case (nxt_state_s)
                ST_PARK: begin
                    gnt_n_r   <= gnt_vec(PARK_IDX);
                    gnt_idx_r <= PARK_IDX;
                    gnt_vld_r <= 1'b1;
                end
                ST_GRANT, ST_BUSY: begin
                    gnt_n_r   <= gnt_vec(nxt_owner_s);
                    gnt_idx_r <= nxt_owner_s;
                    gnt_vld_r <= 1'b1;
                end
                default: begin
                    gnt_n_r   <= {N{1'b1}};
                    gnt_idx_r <= 3'd0;
                    gnt_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign GNT_n   = gnt_n_r;
    assign GNT_IDX = gnt_idx_r;
    assign GNT_VLD = gnt_vld_r;
    assign TMO     = tmo_r;

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter (N=4, PARK=0, TIMEOUT=16): expected bus
// outputs are queued with each stimulus cycle and compared after the edge.
module tb_pci_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] gnt_n;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       tmo;

    typedef struct packed {
        logic [3:0] gnt;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pci_arbiter #(.N(4), .PARK(0), .TIMEOUT(16)) dut (
        .PCI_CLK (clk),
        .RESET_n (rst_n),
        .REQ_n   (req_n),
        .FRAME_n (frame_n),
        .IRDY_n  (irdy_n),
        .GNT_n   (gnt_n),
        .GNT_IDX (gnt_idx),
        .GNT_VLD (gnt_vld),
        .TMO     (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, queue the expected post-edge outputs, compare
    task automatic step(input logic [3:0] req, input logic frame, input logic irdy,
                        input logic [3:0] egnt, input logic etmo);
        exp_t e;
        int   eidx;
        req_n   = req;
        frame_n = frame;
        irdy_n  = irdy;
        exp_q.push_back({egnt, etmo});
        @(posedge clk);
        #1;
        e    = exp_q.pop_front();
        eidx = 0;
        for (int i = 0; i < 4; i++) begin
            if (!e.gnt[i]) eidx = i;
        end
        chk("gnt_n", 32'(gnt_n), 32'(e.gnt));
        chk("gnt_vld", 32'(gnt_vld), 32'(e.gnt != 4'hF));
        if (e.gnt != 4'hF) chk("gnt_idx", 32'(gnt_idx), 32'(eidx));
        chk("tmo", 32'(tmo), 32'(e.tmo));
        chk("onehot", 32'($countones(~gnt_n) <= 1), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n   = 1'b0;
        req_n   = 4'hF;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt_n), 32'hF);
        chk("rst_vld", 32'(gnt_vld), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        rst_n = 1'b1;

        // Park after reset, then slot 2 through turnaround, busy and back to park
        step(4'b1111, 1'b1, 1'b1, 4'b1110, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b1110, 1'b0);
        step(4'b1011, 1'b1, 1'b1, 4'b1111, 1'b0);
        step(4'b1011, 1'b1, 1'b1, 4'b1011, 1'b0);
        step(4'b1011, 1'b0, 1'b1, 4'b1011, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 4'b1011, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b1110, 1'b0);

        // Hidden arbitration: slot 0 takes over from busy slot 2 without a gap
        step(4'b1011, 1'b1, 1'b1, 4'b1111, 1'b0);
        step(4'b1011, 1'b1, 1'b1, 4'b1011, 1'b0);
        step(4'b1011, 1'b0, 1'b1, 4'b1011, 1'b0);
        step(4'b1010, 1'b0, 1'b0, 4'b1110, 1'b0);
        step(4'b1010, 1'b1, 1'b0, 4'b1110, 1'b0);
        step(4'b1110, 1'b1, 1'b1, 4'b1110, 1'b0);
        step(4'b1110, 1'b0, 1'b1, 4'b1110, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b1110, 1'b0);

        // Slots 1 and 3 alternate with one-cycle transactions
        for (int r = 0; r < 4; r++) begin
            logic [3:0] g;
            g = (r % 2 == 0) ? 4'b1101 : 4'b0111;
            step(4'b0101, 1'b1, 1'b1, 4'b1111, 1'b0);
            step(4'b0101, 1'b1, 1'b1, g, 1'b0);
            step(4'b0101, 1'b0, 1'b1, g, 1'b0);
        end
        step(4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b1110, 1'b0);

        // Unused grant to slot 1 revoked after 16 idle edges; slot 2 follows
        step(4'b1001, 1'b1, 1'b1, 4'b1111, 1'b0);
        step(4'b1001, 1'b1, 1'b1, 4'b1101, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            step(4'b1001, 1'b1, 1'b1, 4'b1101, 1'b0);
        end
        step(4'b1001, 1'b1, 1'b1, 4'b1111, 1'b1);
        step(4'b1001, 1'b1, 1'b1, 4'b1011, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b1110, 1'b0);

        // Reset mid-transaction drops grants at once; slot 0 then beats slot 3
        step(4'b0111, 1'b1, 1'b1, 4'b1111, 1'b0);
        step(4'b0111, 1'b1, 1'b1, 4'b0111, 1'b0);
        step(4'b0111, 1'b0, 1'b1, 4'b0111, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(gnt_n), 32'hF);
        chk("async_rst_vld", 32'(gnt_vld), 32'd0);
        #2;
        rst_n   = 1'b1;
        frame_n = 1'b1;
        step(4'b0110, 1'b1, 1'b1, 4'b1110, 1'b0);
        step(4'b0110, 1'b1, 1'b1, 4'b1110, 1'b0);
        step(4'b0110, 1'b0, 1'b1, 4'b1110, 1'b0);
        step(4'b0110, 1'b1, 1'b1, 4'b1111, 1'b0);
        step(4'b0110, 1'b1, 1'b1, 4'b0111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
